// File: rtl/switch_pkg.sv
// Shared types and constants for the two-channel switch debouncer.
package switch_pkg;

   // Default qualification time: 10 ms at 25 MHz.
   localparam int unsigned DEFAULT_DEBOUNCE_LIMIT = 250000;

   // Per-channel FSM: IDLE when sync matches output, QUALIFY while counting a change.
   typedef enum logic {
      IDLE    = 1'b0,
      QUALIFY = 1'b1
   } deb_state_t;

endpackage : switch_pkg

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchronizer, qualify FSM with saturating
// counter, and optional registered edge pulses (SWITCH_DEBOUNCE_EDGE_EN).
module debounce_channel
   import switch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
   input  logic i_Clk,
   input  logic i_Rst_n,
   input  logic i_Switch,
`ifdef SWITCH_DEBOUNCE_EDGE_EN
   output logic o_Rise,
   output logic o_Fall,
`endif
   output logic o_Switch
);

   localparam int unsigned         CNT_W    = $clog2(DEBOUNCE_LIMIT);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

   logic             meta;
   logic             sync;
   deb_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             out_nxt;

   // Two-flop synchronizer for the asynchronous pad level.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= i_Switch;
         sync <= meta;
      end
   end

   // State, counter and debounced level registers.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         o_Switch <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         o_Switch <= out_nxt;
      end
   end

   // Next-state logic: count consecutive differing samples, flip at the limit.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      out_nxt   = o_Switch;
      case (state)
         IDLE: begin
            if (sync != o_Switch) begin
               state_nxt = QUALIFY;
               cnt_nxt   = CNT_W'(1);
            end
         end
         QUALIFY: begin
            if (sync == o_Switch) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               out_nxt   = ~o_Switch;
            end else begin
               cnt_nxt   = cnt + CNT_W'(1);
            end
         end
      endcase
   end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
   // One-cycle pulses registered on the same edge the level flips.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         o_Rise <= 1'b0;
         o_Fall <= 1'b0;
      end else begin
         o_Rise <= out_nxt & ~o_Switch;
         o_Fall <= ~out_nxt & o_Switch;
      end
   end
`endif

endmodule : debounce_channel

// File: rtl/switch_debounce.sv
// Two independent switch debouncers. Define SWITCH_DEBOUNCE_EDGE_EN to add
// registered rise/fall pulse outputs per channel.
module switch_debounce
   import switch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
   input  logic i_Clk,
   input  logic i_Rst_n,
   input  logic i_Switch_1,
   input  logic i_Switch_2,
`ifdef SWITCH_DEBOUNCE_EDGE_EN
   output logic o_Rise_1,
   output logic o_Fall_1,
   output logic o_Rise_2,
   output logic o_Fall_2,
`endif
   output logic o_Switch_1,
   output logic o_Switch_2
);

   // Channel 1.
   debounce_channel #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
   ) u_ch1 (
      .i_Clk    (i_Clk),
      .i_Rst_n  (i_Rst_n),
      .i_Switch (i_Switch_1),
`ifdef SWITCH_DEBOUNCE_EDGE_EN
      .o_Rise   (o_Rise_1),
      .o_Fall   (o_Fall_1),
`endif
      .o_Switch (o_Switch_1)
   );

   // Channel 2.
   debounce_channel #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
   ) u_ch2 (
      .i_Clk    (i_Clk),
      .i_Rst_n  (i_Rst_n),
      .i_Switch (i_Switch_2),
`ifdef SWITCH_DEBOUNCE_EDGE_EN
      .o_Rise   (o_Rise_2),
      .o_Fall   (o_Fall_2),
`endif
      .o_Switch (o_Switch_2)
   );

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce with DEBOUNCE_LIMIT=4; edge-pulse checks are
// included when SWITCH_DEBOUNCE_EDGE_EN is defined.
module tb_switch_debounce;

   localparam int unsigned L = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic sw1, sw2;
   logic o1, o2;
   logic r1, f1, r2, f2;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   switch_debounce #(.DEBOUNCE_LIMIT(L)) dut (
      .i_Clk      (clk),
      .i_Rst_n    (rst_n),
      .i_Switch_1 (sw1),
      .i_Switch_2 (sw2),
`ifdef SWITCH_DEBOUNCE_EDGE_EN
      .o_Rise_1   (r1),
      .o_Fall_1   (f1),
      .o_Rise_2   (r2),
      .o_Fall_2   (f2),
`endif
      .o_Switch_1 (o1),
      .o_Switch_2 (o2)
   );

`ifndef SWITCH_DEBOUNCE_EDGE_EN
   assign r1 = 1'b0;
   assign f1 = 1'b0;
   assign r2 = 1'b0;
   assign f2 = 1'b0;
`endif

   // Reference model: raw -> two-stage delay -> window of the last L sync
   // samples; the level flips when the whole window disagrees with it.
   logic         ms1 [2];
   logic         ms2 [2];
   logic [L-1:0] hist [2];
   logic         mout [2];
   logic         mrise [2];
   logic         mfall [2];

   function automatic logic win_flip(input logic [L-1:0] h, input logic s, input logic o);
      logic [L-1:0] w;
      w = {h[L-2:0], s};
      return (w == {L{~o}});
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 2; c++) begin
            ms1[c]   <= 1'b0;
            ms2[c]   <= 1'b0;
            hist[c]  <= '0;
            mout[c]  <= 1'b0;
            mrise[c] <= 1'b0;
            mfall[c] <= 1'b0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            hist[c]  <= {hist[c][L-2:0], ms2[c]};
            mrise[c] <= win_flip(hist[c], ms2[c], mout[c]) & ~mout[c];
            mfall[c] <= win_flip(hist[c], ms2[c], mout[c]) & mout[c];
            mout[c]  <= mout[c] ^ win_flip(hist[c], ms2[c], mout[c]);
            ms2[c]   <= ms1[c];
            ms1[c]   <= (c == 0) ? sw1 : sw2;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sw1 = 1'b0; sw2 = 1'b0;
      tick(); tick();
      n_cmp++; if (o1 !== 1'b0 || o2 !== 1'b0) begin n_fail++;
         $display("FAIL reset_levels: got o1=%b o2=%b want 0 0", o1, o2); end
      n_cmp++; if ({r1, f1, r2, f2} !== 4'b0) begin n_fail++;
         $display("FAIL reset_pulses: got %b want 0000", {r1, f1, r2, f2}); end
      sw1 = 1'b1; sw2 = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      n_cmp++; if (o1 !== 1'b0 || o2 !== 1'b0) begin n_fail++;
         $display("FAIL reset_hold: got o1=%b o2=%b want 0 0 while in reset", o1, o2); end
      sw1 = 1'b0; sw2 = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_hold_low();
      for (int i = 0; i < 12; i++) begin
         tick();
         n_cmp++; if (o1 !== 1'b0 || {r1, f1} !== 2'b00) begin n_fail++;
            $display("FAIL hold_low[%0d]: got o1=%b r1=%b f1=%b want 0 0 0", i, o1, r1, f1); end
      end
   endtask

   // Captured at edge N, output flips at edge N+5 (sampled at tick 6).
   task automatic test_rise_latency();
      sw1 = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         n_cmp++; if (o1 !== (i >= 6)) begin n_fail++;
            $display("FAIL rise1_level[%0d]: got %b want %b", i, o1, (i >= 6)); end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
         n_cmp++; if (r1 !== (i == 6) || f1 !== 1'b0) begin n_fail++;
            $display("FAIL rise1_pulse[%0d]: got r=%b f=%b want r=%b f=0", i, r1, f1, (i == 6)); end
`endif
      end
   endtask

   task automatic test_glitch();
      sw2 = 1'b1;
      tick(); tick(); tick();
      sw2 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_cmp++; if (o2 !== 1'b0 || {r2, f2} !== 2'b00) begin n_fail++;
            $display("FAIL glitch2[%0d]: got o2=%b r2=%b f2=%b want 0 0 0", i, o2, r2, f2); end
      end
      // Counter must be cleared: a held change needs the full latency again.
      sw2 = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         n_cmp++; if (o2 !== (i >= 6)) begin n_fail++;
            $display("FAIL requal2[%0d]: got %b want %b", i, o2, (i >= 6)); end
      end
   endtask

   task automatic test_both();
      sw1 = 1'b0; sw2 = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      n_cmp++; if (o1 !== 1'b0 || o2 !== 1'b0) begin n_fail++;
         $display("FAIL both_settle: got o1=%b o2=%b want 0 0", o1, o2); end
      sw1 = 1'b1; sw2 = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         n_cmp++; if (o1 !== (i >= 6) || o2 !== (i >= 6) || (o1 & o2) !== (i >= 6)) begin n_fail++;
            $display("FAIL both_rise[%0d]: got o1=%b o2=%b and=%b want %b", i, o1, o2, o1 & o2, (i >= 6)); end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
         n_cmp++; if (r1 !== (i == 6) || r2 !== (i == 6)) begin n_fail++;
            $display("FAIL both_pulse[%0d]: got r1=%b r2=%b want %b", i, r1, r2, (i == 6)); end
`endif
      end
   endtask

   task automatic test_reset_mid();
      sw1 = 1'b0; sw2 = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      sw1 = 1'b1;
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      n_cmp++; if (o1 !== 1'b0 || o2 !== 1'b0) begin n_fail++;
         $display("FAIL midreset_levels: got o1=%b o2=%b want 0 0", o1, o2); end
      tick();
      rst_n = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         n_cmp++; if (o1 !== (i >= 6)) begin n_fail++;
            $display("FAIL midreset_requal[%0d]: got %b want %b", i, o1, (i >= 6)); end
      end
   endtask

   task automatic test_random();
      int hold1 = 0;
      int hold2 = 0;
      for (int i = 0; i < 400; i++) begin
         if (hold1 == 0) begin sw1 = 1'($urandom_range(0, 1)); hold1 = int'($urandom_range(1, 8)); end
         if (hold2 == 0) begin sw2 = 1'($urandom_range(0, 1)); hold2 = int'($urandom_range(1, 8)); end
         hold1--; hold2--;
         tick();
         n_cmp++; if (o1 !== mout[0] || o2 !== mout[1]) begin n_fail++;
            $display("FAIL random_level[%0d]: got %b%b want %b%b", i, o1, o2, mout[0], mout[1]); end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
         n_cmp++; if ({r1, f1, r2, f2} !== {mrise[0], mfall[0], mrise[1], mfall[1]}) begin n_fail++;
            $display("FAIL random_pulse[%0d]: got %b want %b", i, {r1, f1, r2, f2},
                     {mrise[0], mfall[0], mrise[1], mfall[1]}); end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_hold_low();
      test_rise_latency();
      test_glitch();
      test_both();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_switch_debounce

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_LIMIT, default 250000, the number of consecutive i_Clk cycles a changed synchronized level must hold before it is accepted (10 ms at 25 MHz); legal range >= 2.
REQ-002 SHALL have port i_Clk, input, 1, the single system clock; all state on rising edge.
REQ-003 SHALL have port i_Rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-004 SHALL have port i_Switch_1, input, 1, raw asynchronous switch 1 pad level.
REQ-005 SHALL have port i_Switch_2, input, 1, raw asynchronous switch 2 pad level.
REQ-006 SHALL have port o_Switch_1, output, 1, debounced level of switch 1, which feeds the downstream AND-gate stage.
REQ-007 SHALL have port o_Switch_2, output, 1, debounced level of switch 2, which feeds the downstream AND-gate stage.
REQ-008 SHALL have ports o_Rise_1, o_Fall_1, o_Rise_2, o_Fall_2, output, 1 each, one-cycle edge pulses of the debounced levels; these ports are present only under REQ-021.

Function
REQ-009 SHALL pass each raw input through a 2-flop synchronizer; the second flop is the "sync" level.
REQ-010 SHALL have per-channel state machine states IDLE (sync equals stable output) and QUALIFY (sync differs; counting).
REQ-011 SHALL, in IDLE, when sync != output: go to QUALIFY and load the counter with 1.
REQ-012 SHALL, in QUALIFY, when sync == output: return to IDLE, clear the counter, and leave the output unchanged; this is glitch rejection.
REQ-013 SHALL, in QUALIFY, when sync != output and counter < DEBOUNCE_LIMIT-1: increment the counter.
REQ-014 SHALL, in QUALIFY, when sync != output and counter == DEBOUNCE_LIMIT-1: invert the output, clear the counter, and go to IDLE.
REQ-015 SHALL meet this latency: if a new level is captured by the first sync flop at edge N and held, the output changes at edge N+1+DEBOUNCE_LIMIT.
REQ-016 SHALL size the counter as $clog2(DEBOUNCE_LIMIT) bits, and the counter SHALL never wrap; it saturates by construction of REQ-014.
REQ-017 SHALL keep the two channels fully independent; simultaneous changes on both inputs qualify in parallel with identical latency.
REQ-018 SHALL drive the outputs directly from flops, with no combinational path from input to output.

Reset
REQ-019 SHALL, while i_Rst_n=0, force immediately: both sync flops 0, counter 0, state IDLE, o_Switch_x 0, and edge pulses 0.
REQ-020 SHALL, when reset asserts mid-QUALIFY, abandon the qualification; after release, a held input re-qualifies from scratch, with full REQ-015 latency measured from the first post-reset capture.

Configuration
REQ-021 SHALL, with macro SWITCH_DEBOUNCE_EDGE_EN defined, provide the o_Rise_x and o_Fall_x ports. o_Rise_x is high for exactly the one cycle following the edge at which o_Switch_x goes 0->1; o_Fall_x behaves likewise for 1->0. Both are registered.
REQ-022 SHALL, without SWITCH_DEBOUNCE_EDGE_EN, have neither those ports nor their logic present; level outputs and timing stay identical.

Structure
REQ-023 SHALL put the state enum (IDLE, QUALIFY) and the constant DEFAULT_DEBOUNCE_LIMIT=250000 in shared package switch_pkg.
REQ-024 SHALL implement one channel (synchronizer, FSM, counter, optional edge logic) as sub-module debounce_channel, instantiated twice.

Verification (DEBOUNCE_LIMIT=4)
REQ-025 SHALL cover: reset, then i_Switch_1 held at 0 -> o_Switch_1=0, no pulses, FSM stays IDLE.
REQ-026 SHALL cover: i_Switch_1 0->1 captured at edge 10 and held -> o_Switch_1 rises at edge 15; o_Rise_1=1 for that single cycle only.
REQ-027 SHALL cover: i_Switch_2 high for 3 cycles then low -> o_Switch_2 stays 0, counter returns to 0, no pulse.
REQ-028 SHALL cover: both switches rise on the same edge -> both outputs rise on the same edge, 5 cycles after capture; the downstream AND result goes 1 then.
REQ-029 SHALL cover: i_Rst_n pulsed low during QUALIFY with input held at 1 -> outputs 0 during reset; after release, the output rises 5 cycles after the first capture.
REQ-030 SHALL cover: a build without SWITCH_DEBOUNCE_EDGE_EN -> compiles without the edge ports, and REQ-026 level timing is unchanged.
